serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/ha_cell.sv | 12 +
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell; two of these plus a carry flop form one full-adder slice.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, parallel result with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_adder: WIDTH %0d outside 2..%0d", WIDTH, WIDTH_MAX);
    end

    state_t           state;
    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    cnt;
    logic             carry_q;

    logic p, g1, s_bit, g2, carry_d;
    logic [WIDTH-1:0] sum_nxt;

    ha_cell u_ha1 (.x(opa_sr[0]), .y(opb_sr[0]), .s(p),     .c(g1));
    ha_cell u_ha2 (.x(p),         .y(carry_q),   .s(s_bit), .c(g2));

    assign carry_d = g1 | g2;
    assign sum_nxt = {s_bit, sum_sr[WIDTH-1:1]};

    // busy/done are set alongside the state so they come straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            opa_sr  <= '0;
            opb_sr  <= '0;
            sum_sr  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa_sr  <= a;
                        opb_sr  <= b;
                        carry_q <= 1'b0;
                        cnt     <= '0;
                        sum_sr  <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry_q <= carry_d;
                    sum_sr  <= sum_nxt;
                    opa_sr  <= opa_sr >> 1;
                    opb_sr  <= opb_sr >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= sum_nxt;
                        cout  <= carry_d;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the 8-bit instance; returns edges waited and busy cycles seen.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
    endtask

    task automatic add8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] es, input logic ec);
        int n, nb;
        a = ta; b = tb_v; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, nb);
        chk({tag, "_lat"},  n,    8);
        chk({tag, "_busy"}, nb,   8);
        chk({tag, "_sum"},  sum,  es);
        chk({tag, "_cout"}, cout, ec);
        tick();
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int n, nb, pulses;
        bit seen;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum",  sum,  0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        add8("t0f01", 8'h0F, 8'h01, 8'h10, 1'b0);
        add8("tff01", 8'hFF, 8'h01, 8'h00, 1'b1);
        add8("taa55", 8'hAA, 8'h55, 8'hFF, 1'b0);

        // second start mid-run and operand changes must not disturb the sum
        a = 8'h03; b = 8'h04; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h5A; b = 8'hC3;
        chk("ign_busy", busy, 1);
        wait_done(n, nb);
        chk("ign_lat",  n,    5);
        chk("ign_sum",  sum,  8'h07);
        chk("ign_cout", cout, 0);
        tick();
        chk("ign_norestart", busy, 0);

        // reset mid-shift aborts the add
        a = 8'h80; b = 8'h80; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum",  sum,  0);
        chk("abort_cout", cout, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", done, 0);
        end
        rst_n = 1'b1;
        tick();
        chk("abort_idle", busy, 0);
        add8("t8080", 8'h80, 8'h80, 8'h00, 1'b1);

        // start held high: repeated results, sum steady between pulses
        a = 8'h01; b = 8'h01; start = 1'b1;
        pulses = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                pulses++;
                seen = 1'b1;
            end
            if (seen) chk("cont_sum", sum, 8'h02);
        end
        start = 1'b0;
        chk("cont_pulses", (pulses >= 3) ? 1 : 0, 1);

        // WIDTH=4 instance
        a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            tick();
            n++;
        end
        chk("w4_lat",  n,     4);
        chk("w4_sum",  sum4,  4'hE);
        chk("w4_cout", cout4, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
